skolem_bvneg_sweep_checker: RTL and testbench

Sequential sweep-and-check engine that sits directly upstream and downstream of the combinational 4-bit bvneg inverse Skolem function. It drives every W-bit target value into the Skolem block's inputs and captures the candidate it returns. It checks that negating the candidate reproduces the target, then reports pass/fail statistics and the first failing target. It exhaustively certifies a generated Skolem netlist in simulation or on an FPGA harness.

---
 rtl/skolem_bvneg_sweep_checker_if.sv | 26 ++
 rtl/skolem_bvneg_sweep_checker.sv | 124 ++++++++++++
 tb/tb_skolem_bvneg_sweep_checker.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/skolem_bvneg_sweep_checker_if.sv
// rtl/skolem_bvneg_sweep_checker_if.sv - sweep checker control, Skolem-block and status signals
interface skolem_bvneg_sweep_checker_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] tgt_o;
  logic [W-1:0] cand_i;
  logic         busy;
  logic         done;
  logic         pass;
  logic [W:0]   pass_cnt;
  logic [W:0]   fail_cnt;
  logic         first_fail_vld;
  logic [W-1:0] first_fail_tgt;

  // master: host plus Skolem block under test; slave: the checker
  modport master (
    output start, cand_i,
    input  tgt_o, busy, done, pass, pass_cnt, fail_cnt, first_fail_vld, first_fail_tgt
  );

  modport slave (
    input  start, cand_i,
    output tgt_o, busy, done, pass, pass_cnt, fail_cnt, first_fail_vld, first_fail_tgt
  );
endinterface

// File: rtl/skolem_bvneg_sweep_checker.sv
// rtl/skolem_bvneg_sweep_checker.sv - exhaustive sweep/check engine for a bvneg inverse Skolem block
// Optional feature: SKOLEM_CHK_STOP_ON_FAIL_EN ends the sweep at the first failing target.
module skolem_bvneg_sweep_checker #(
  parameter int W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  skolem_bvneg_sweep_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] TGT_MAX = '1;
  localparam logic [W-1:0] TGT_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   CNT_ONE = {{W{1'b0}}, 1'b1};

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] tgt_q;
  logic [W-1:0] s1_tgt;
  logic [W-1:0] s1_cand;
  logic         s1_vld;
  logic [W:0]   pass_cnt_q;
  logic [W:0]   fail_cnt_q;
  logic         ff_vld_q;
  logic [W-1:0] ff_tgt_q;

  logic [W-1:0] neg_cand;
  logic         chk_ok;
  logic         chk_fail;
  logic         stop_now;
  logic         launch;
  logic         advance;

  // W-bit two's complement negation; wraps so -0 = 0 and -2^(W-1) = 2^(W-1)
  assign neg_cand = ~s1_cand + TGT_ONE;
  assign chk_ok   = (neg_cand == s1_tgt);
  assign chk_fail = s1_vld && !chk_ok;

`ifdef SKOLEM_CHK_STOP_ON_FAIL_EN
  assign stop_now = chk_fail;
`else
  assign stop_now = 1'b0;
`endif

  assign launch  = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign advance = (state_q == SWEEP) && (state_d == SWEEP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = SWEEP;
      SWEEP: begin
        if (stop_now)               state_d = DONE;
        else if (tgt_q == TGT_MAX)  state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE:  if (bus.start) state_d = SWEEP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      s1_tgt     <= '0;
      s1_cand    <= '0;
      s1_vld     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ff_vld_q   <= 1'b0;
      ff_tgt_q   <= '0;
    end else begin
      state_q <= state_d;

      if (launch) begin
        tgt_q <= '0;
      end else if (advance) begin
        tgt_q <= tgt_q + TGT_ONE;
      end

      // Stage 1: capture target/candidate pair; a stop discards the in-flight pair
      s1_vld <= (state_q == SWEEP) && !stop_now;
      if (state_q == SWEEP) begin
        s1_tgt  <= tgt_q;
        s1_cand <= bus.cand_i;
      end

      // Stage 2: score the captured pair; launch never overlaps a valid pair
      if (launch) begin
        pass_cnt_q <= '0;
        fail_cnt_q <= '0;
        ff_vld_q   <= 1'b0;
        ff_tgt_q   <= '0;
      end else if (s1_vld) begin
        if (chk_ok) begin
          pass_cnt_q <= pass_cnt_q + CNT_ONE;
        end else begin
          fail_cnt_q <= fail_cnt_q + CNT_ONE;
          if (!ff_vld_q) begin
            ff_vld_q <= 1'b1;
            ff_tgt_q <= s1_tgt;
          end
        end
      end
    end
  end

  assign bus.tgt_o          = tgt_q;
  assign bus.busy           = (state_q == SWEEP) || (state_q == DRAIN);
  assign bus.done           = (state_q == DONE);
  assign bus.pass           = (state_q == DONE) && (fail_cnt_q == '0);
  assign bus.pass_cnt       = pass_cnt_q;
  assign bus.fail_cnt       = fail_cnt_q;
  assign bus.first_fail_vld = ff_vld_q;
  assign bus.first_fail_tgt = ff_tgt_q;

endmodule

// File: tb/tb_skolem_bvneg_sweep_checker.sv
// tb/tb_skolem_bvneg_sweep_checker.sv - scoreboard bench for skolem_bvneg_sweep_checker
module tb_skolem_bvneg_sweep_checker;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic       fault_en;
  logic [3:0] fault_tgt;
  logic [3:0] fault_val;

  typedef struct {
    int done_cyc;
    int pcnt;
    int fcnt;
    int ffv;
    int fft;
    int last_tgt;
  } exp_t;

  exp_t sb[$];

  skolem_bvneg_sweep_checker_if #(.W(4)) bus ();

  skolem_bvneg_sweep_checker #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Skolem block model: correct negation except one optionally planted fault
  always_comb begin
    if (fault_en && (bus.tgt_o == fault_tgt)) bus.cand_i = fault_val;
    else                                      bus.cand_i = 4'd0 - bus.tgt_o;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int model_cand(input int t);
    if (fault_en && (t == int'(fault_tgt))) return int'(fault_val);
    return (16 - t) % 16;
  endfunction

  function automatic exp_t build_exp();
    exp_t e;
    int   c;
    bit   stopped;
    e.done_cyc = 17;
    e.pcnt     = 0;
    e.fcnt     = 0;
    e.ffv      = 0;
    e.fft      = 0;
    e.last_tgt = 15;
    stopped    = 0;
    for (int t = 0; t < 16; t++) begin
      if (!stopped) begin
        c = model_cand(t);
        if (((16 - c) & 15) == t) begin
          e.pcnt++;
        end else begin
          e.fcnt++;
          if (e.ffv == 0) begin
            e.ffv = 1;
            e.fft = t;
          end
`ifdef SKOLEM_CHK_STOP_ON_FAIL_EN
          stopped    = 1;
          e.done_cyc = t + 2;
          e.last_tgt = (t + 1 > 15) ? 15 : t + 1;
`endif
        end
      end
    end
    return e;
  endfunction

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_tgt"},  bus.tgt_o, 0);
    check({pfx, "_busy"}, bus.busy, 0);
    check({pfx, "_done"}, bus.done, 0);
    check({pfx, "_pass"}, bus.pass, 0);
    check({pfx, "_pcnt"}, bus.pass_cnt, 0);
    check({pfx, "_fcnt"}, bus.fail_cnt, 0);
    check({pfx, "_ffv"},  bus.first_fail_vld, 0);
    check({pfx, "_fft"},  bus.first_fail_tgt, 0);
  endtask

  task automatic run_sweep(input bit fen, input int ft, input int fv, input bit extra);
    exp_t e;
    exp_t x;
    int   k;
    fault_en  = fen;
    fault_tgt = 4'(ft);
    fault_val = 4'(fv);
    x = build_exp();
    sb.push_back(x);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 40) begin
      if (k == 0) begin
        check("clr_pcnt", bus.pass_cnt, 0);
        check("clr_fcnt", bus.fail_cnt, 0);
        check("clr_ffv",  bus.first_fail_vld, 0);
      end
      check("tgt",  bus.tgt_o, (k <= x.last_tgt) ? k : x.last_tgt);
      check("busy", bus.busy, 1);
      if (extra && (k == 3 || k == 16)) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      k++;
    end
    e = sb.pop_front();
    check("done_cyc", k, e.done_cyc);
    check("done",     bus.done, 1);
    check("busy_end", bus.busy, 0);
    check("pass_cnt", bus.pass_cnt, e.pcnt);
    check("fail_cnt", bus.fail_cnt, e.fcnt);
    check("ff_vld",   bus.first_fail_vld, e.ffv);
    check("ff_tgt",   bus.first_fail_tgt, e.fft);
    check("pass",     bus.pass, (e.fcnt == 0) ? 1 : 0);
    check("tgt_hold", bus.tgt_o, e.last_tgt);
    repeat (2) @(negedge clk);
    check("hold_done", bus.done, 1);
    check("hold_pcnt", bus.pass_cnt, e.pcnt);
  endtask

  task automatic reset_mid_sweep();
    fault_en  = 1'b1;
    fault_tgt = 4'd2;
    fault_val = 4'd3;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_ffv", bus.first_fail_vld, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_async");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_idle");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fault_en    = 1'b0;
    fault_tgt   = 4'd0;
    fault_val   = 4'd0;
    bus.start   = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(1'b0, 0, 0, 1'b1);
    run_sweep(1'b1, 5, 0, 1'b0);
    run_sweep(1'b1, 8, 7, 1'b0);
    run_sweep(1'b1, 0, 1, 1'b0);
    run_sweep(1'b1, 15, 0, 1'b0);
    reset_mid_sweep();
    run_sweep(1'b0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
